// File: rtl/po_scan_loader.sv
// po_scan_loader: serially loads a parallel word into a chain of io_po tiles
// while capturing the previous chain contents returning from the last tile.
`default_nettype none

module po_scan_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 po_scan_loader_clk,
    input  logic                 po_scan_loader_reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [CHAIN_LEN-1:0] load_data,
    output logic                 chain_sc_out,
    input  logic                 chain_sc_in,
    output logic                 chain_se,
    output logic                 cap_valid,
    input  logic                 cap_ready,
    output logic [CHAIN_LEN-1:0] cap_data,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CHAIN_LEN-2:0] cap_shift_q, cap_shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 se_q, se_d;
    logic                 sc_out_q, sc_out_d;
    logic                 cap_valid_q, cap_valid_d;
    logic [CHAIN_LEN-1:0] cap_data_q, cap_data_d;
    logic                 load_ready_q, load_ready_d;
    logic                 busy_q, busy_d;

    logic                 w_accept;
    logic                 w_last;
    logic [CHAIN_LEN-1:0] w_cap_full;

    assign w_accept   = (state_q == S_IDLE) && load_valid && load_ready_q;
    assign w_last     = (state_q == S_SHIFT) && (cnt_q == CNT_W'(CHAIN_LEN - 1));
    // First bit sampled is the old last-tile value; it walks up to the MSB.
    assign w_cap_full = {cap_shift_q, chain_sc_in};

    always_ff @(posedge po_scan_loader_clk or posedge po_scan_loader_reset) begin
        if (po_scan_loader_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept)  state_d = S_SHIFT;
            S_SHIFT: if (w_last)    state_d = S_DONE;
            S_DONE:  if (cap_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        cap_shift_d  = cap_shift_q;
        cnt_d        = cnt_q;
        se_d         = se_q;
        sc_out_d     = sc_out_q;
        cap_valid_d  = cap_valid_q;
        cap_data_d   = cap_data_q;
        load_ready_d = load_ready_q;
        busy_d       = busy_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    // MSB goes straight onto the chain; the rest queue behind it.
                    shift_d      = load_data << 1;
                    sc_out_d     = load_data[CHAIN_LEN-1];
                    cap_shift_d  = '0;
                    cnt_d        = '0;
                    se_d         = 1'b1;
                    load_ready_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            S_SHIFT: begin
                cap_shift_d = w_cap_full[CHAIN_LEN-2:0];
                shift_d     = shift_q << 1;
                if (w_last) begin
                    cnt_d       = '0;
                    se_d        = 1'b0;
                    sc_out_d    = 1'b0;
                    cap_valid_d = 1'b1;
                    cap_data_d  = w_cap_full;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    sc_out_d = shift_q[CHAIN_LEN-1];
                end
            end
            S_DONE: begin
                if (cap_ready) begin
                    cap_valid_d  = 1'b0;
                    load_ready_d = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                se_d         = 1'b0;
                sc_out_d     = 1'b0;
                cap_valid_d  = 1'b0;
                load_ready_d = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge po_scan_loader_clk or posedge po_scan_loader_reset) begin
        if (po_scan_loader_reset) begin
            shift_q      <= '0;
            cap_shift_q  <= '0;
            cnt_q        <= '0;
            se_q         <= 1'b0;
            sc_out_q     <= 1'b0;
            cap_valid_q  <= 1'b0;
            cap_data_q   <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cap_shift_q  <= cap_shift_d;
            cnt_q        <= cnt_d;
            se_q         <= se_d;
            sc_out_q     <= sc_out_d;
            cap_valid_q  <= cap_valid_d;
            cap_data_q   <= cap_data_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign load_ready   = load_ready_q;
    assign chain_sc_out = sc_out_q;
    assign chain_se     = se_q;
    assign cap_valid    = cap_valid_q;
    assign cap_data     = cap_data_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire
